axis_processor_arbiter: RTL and testbench

AXIS_PROCESSOR_ARBITER -- requirements
Module: axis_processor_arbiter

---
 rtl/axis_processor_arbiter_pkg.sv | 17 +
 rtl/axis_processor_arbiter_tag_fifo.sv | 50 +++++
 rtl/axis_processor_arbiter.sv | 128 ++++++++++++
 tb/tb_axis_processor_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_processor_arbiter_pkg.sv
// Shared configuration for the AXI-Stream processor arbiter.
// Processor stream widths plus arbiter state and id helpers.
package processor_config;
  localparam int INP_WIDTH = 16;
  localparam int OUT_WIDTH = 8;
endpackage

package arbiter_config;
  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_processor_arbiter_tag_fifo.sv
// Synchronous tag FIFO recording which requester owns each
// outstanding packet, in packet order.
module tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/axis_processor_arbiter.sv
// Round-robin packet arbiter feeding one shared processor and
// routing each processor result back to the packet's owner.
module axis_processor_arbiter
  import processor_config::*;
  import arbiter_config::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_DEPTH = 8,
  localparam int ID_WIDTH = id_width(NUM_REQ),
  localparam int CNT_WIDTH = $clog2(TAG_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0][INP_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_REQ-1:0]                 s_axis_tvalid,
  input  logic [NUM_REQ-1:0]                 s_axis_tlast,
  output logic [NUM_REQ-1:0]                 s_axis_tready,
  output logic [INP_WIDTH-1:0]               m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  input  logic [OUT_WIDTH-1:0]               p_axis_tdata,
  input  logic                               p_axis_tvalid,
  output logic                               p_axis_tready,
  output logic [OUT_WIDTH-1:0]               r_axis_tdata,
  output logic [NUM_REQ-1:0]                 r_axis_tvalid,
  input  logic [NUM_REQ-1:0]                 r_axis_tready,
  output logic [ID_WIDTH-1:0]                grant_id,
  output logic                               busy,
  output logic [CNT_WIDTH-1:0]               outstanding,
  output logic                               orphan_err
);
  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic                orphan_q, orphan_d;
  logic                pick_vld;
  logic [ID_WIDTH-1:0] pick;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [ID_WIDTH-1:0] head;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && s_axis_tvalid[(int'(rr_q) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick     = ID_WIDTH'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    push          = 1'b0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata[grant_q];
    unique case (state_q)
      IDLE: begin
        if (pick_vld && !fifo_full) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        if (s_axis_tvalid[grant_q] && m_axis_tready &&
            s_axis_tlast[grant_q]) begin
          push    = 1'b1;
          rr_d    = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ?
                    '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    r_axis_tdata  = p_axis_tdata;
    r_axis_tvalid = '0;
    p_axis_tready = 1'b0;
    if (!fifo_empty) begin
      r_axis_tvalid[head] = p_axis_tvalid;
      p_axis_tready       = r_axis_tready[head];
    end
  end

  assign pop      = p_axis_tvalid && p_axis_tready;
  assign orphan_d = orphan_q | (p_axis_tvalid & fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      grant_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      orphan_q <= orphan_d;
    end
  end

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (ID_WIDTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (grant_q),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding)
  );

  assign grant_id   = grant_q;
  assign busy       = (state_q == LOCKED);
  assign orphan_err = orphan_q;
endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Directed bench for axis_processor_arbiter (NUM_REQ 4, TAG_DEPTH 2).
// Cycle table for the basic flow plus hand-written corner sequences.
module tb_axis_processor_arbiter;
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][15:0] s_tdata;
  logic [3:0]       s_tvalid, s_tlast, s_tready;
  logic [15:0]      m_tdata;
  logic             m_tvalid, m_tready;
  logic [7:0]       p_tdata;
  logic             p_tvalid, p_tready;
  logic [7:0]       r_tdata;
  logic [3:0]       r_tvalid, r_tready;
  logic [1:0]       grant_id;
  logic             busy;
  logic [1:0]       outstanding;
  logic             orphan_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_processor_arbiter #(
    .NUM_REQ   (4),
    .TAG_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .p_axis_tdata  (p_tdata),
    .p_axis_tvalid (p_tvalid),
    .p_axis_tready (p_tready),
    .r_axis_tdata  (r_tdata),
    .r_axis_tvalid (r_tvalid),
    .r_axis_tready (r_tready),
    .grant_id      (grant_id),
    .busy          (busy),
    .outstanding   (outstanding),
    .orphan_err    (orphan_err)
  );

  typedef struct {
    logic [3:0] sv;
    logic [3:0] sl;
    logic       mr;
    logic       pv;
    logic [3:0] rr;
    logic [3:0] str;
    logic       mv;
    logic [1:0] gid;
    logic       bsy;
    logic [1:0] outs;
    logic       pr;
    logic [3:0] rv;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic rst_dut();
    @(negedge clk);
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    p_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1:0] got [5];
    logic [1:0] exp_ord [5];
    int n;
    int c;
    exp_ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) s_tdata[i] = 16'hD000 + 16'(i);
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    p_tdata  = 8'h11;
    p_tvalid = 1'b0;
    r_tready = 4'hF;

    // sv sl mr pv rr | str mv gid busy outs pr rv
    tbl[0]  = '{4'b0000, 4'b0000, 1, 0, 4'hF, 4'b0000, 0, 0, 0, 0, 0, 4'b0000};
    tbl[1]  = '{4'b0101, 4'b0000, 1, 0, 4'hF, 4'b0000, 0, 0, 0, 0, 0, 4'b0000};
    tbl[2]  = '{4'b0101, 4'b0000, 1, 0, 4'hF, 4'b0001, 1, 0, 1, 0, 0, 4'b0000};
    tbl[3]  = '{4'b0101, 4'b0000, 1, 0, 4'hF, 4'b0001, 1, 0, 1, 0, 0, 4'b0000};
    tbl[4]  = '{4'b0101, 4'b0001, 1, 0, 4'hF, 4'b0001, 1, 0, 1, 0, 0, 4'b0000};
    tbl[5]  = '{4'b0100, 4'b0000, 1, 0, 4'hF, 4'b0000, 0, 0, 0, 1, 1, 4'b0000};
    tbl[6]  = '{4'b0100, 4'b0000, 0, 0, 4'hF, 4'b0000, 1, 2, 1, 1, 1, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 1, 0, 4'hF, 4'b0100, 0, 2, 1, 1, 1, 4'b0000};
    tbl[8]  = '{4'b0100, 4'b0000, 1, 0, 4'hF, 4'b0100, 1, 2, 1, 1, 1, 4'b0000};
    tbl[9]  = '{4'b0100, 4'b0000, 1, 0, 4'hF, 4'b0100, 1, 2, 1, 1, 1, 4'b0000};
    tbl[10] = '{4'b0100, 4'b0100, 1, 0, 4'hF, 4'b0100, 1, 2, 1, 1, 1, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 1, 1, 4'hF, 4'b0000, 0, 2, 0, 2, 1, 4'b0001};
    tbl[12] = '{4'b0000, 4'b0000, 1, 1, 4'hF, 4'b0000, 0, 2, 0, 1, 1, 4'b0100};
    tbl[13] = '{4'b0000, 4'b0000, 1, 0, 4'hF, 4'b0000, 0, 2, 0, 0, 0, 4'b0000};

    rst_dut();
    chk("rst_orphan", orphan_err, 1'b0);
    for (int k = 0; k < 14; k++) begin
      s_tvalid = tbl[k].sv;
      s_tlast  = tbl[k].sl;
      m_tready = tbl[k].mr;
      p_tvalid = tbl[k].pv;
      r_tready = tbl[k].rr;
      #1;
      chk($sformatf("t%0d_s_tready", k), s_tready, tbl[k].str);
      chk($sformatf("t%0d_m_tvalid", k), m_tvalid, tbl[k].mv);
      chk($sformatf("t%0d_grant", k), grant_id, tbl[k].gid);
      chk($sformatf("t%0d_busy", k), busy, tbl[k].bsy);
      chk($sformatf("t%0d_outst", k), outstanding, tbl[k].outs);
      chk($sformatf("t%0d_p_tready", k), p_tready, tbl[k].pr);
      chk($sformatf("t%0d_r_tvalid", k), r_tvalid, tbl[k].rv);
      if (tbl[k].mv)
        chk($sformatf("t%0d_m_tdata", k), m_tdata,
            16'hD000 + 16'(tbl[k].gid));
      @(negedge clk);
    end

    // Round robin with every requester sending 1-beat packets.
    rst_dut();
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    m_tready = 1'b1;
    r_tready = 4'hF;
    n = 0;
    for (int cy = 0; cy < 60 && n < 5; cy++) begin
      p_tvalid = (outstanding != 2'd0);
      #1;
      if (busy && s_tready != 4'b0000) begin
        got[n] = grant_id;
        n++;
      end
      @(negedge clk);
    end
    chk("rr_pkt_count", n, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order%0d", i), got[i], exp_ord[i]);
    s_tvalid = '0;
    p_tvalid = 1'b0;

    // Full tag FIFO blocks a third grant.
    rst_dut();
    s_tvalid = 4'b0111;
    s_tlast  = 4'b0111;
    repeat (10) @(negedge clk);
    #1;
    chk("full_outst", outstanding, 2'd2);
    chk("full_busy", busy, 1'b0);
    chk("full_s_tready", s_tready, 4'b0000);
    chk("full_m_tvalid", m_tvalid, 1'b0);
    chk("full_grant", grant_id, 2'd1);
    p_tvalid = 1'b1;
    #1;
    chk("full_head_rv", r_tvalid, 4'b0001);
    @(negedge clk);
    p_tvalid = 1'b0;
    s_tvalid = '0;

    // Responses routed to req1 then req3, with a stall on req3.
    rst_dut();
    s_tvalid = 4'b1010;
    s_tlast  = 4'b1010;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (outstanding == 2'd2) break;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    chk("resp_fill", outstanding, 2'd2);
    p_tdata  = 8'hA5;
    p_tvalid = 1'b1;
    r_tready = 4'hF;
    #1;
    chk("resp1_rv", r_tvalid, 4'b0010);
    chk("resp1_data", r_tdata, 8'hA5);
    chk("resp1_pr", p_tready, 1'b1);
    @(negedge clk);
    p_tdata  = 8'h3C;
    r_tready = 4'b0111;
    #1;
    chk("resp3_rv", r_tvalid, 4'b1000);
    chk("resp3_data", r_tdata, 8'h3C);
    chk("resp3_stall_pr", p_tready, 1'b0);
    chk("resp3_outst", outstanding, 2'd1);
    @(negedge clk);
    #1;
    chk("resp3_hold_rv", r_tvalid, 4'b1000);
    chk("resp3_hold_outst", outstanding, 2'd1);
    r_tready = 4'hF;
    #1;
    chk("resp3_pr", p_tready, 1'b1);
    @(negedge clk);
    p_tvalid = 1'b0;
    #1;
    chk("resp_drain", outstanding, 2'd0);

    // Orphan response with empty FIFO.
    p_tvalid = 1'b1;
    #1;
    chk("orph_pr", p_tready, 1'b0);
    chk("orph_rv", r_tvalid, 4'b0000);
    chk("orph_pre", orphan_err, 1'b0);
    @(negedge clk);
    p_tvalid = 1'b0;
    #1;
    chk("orph_set", orphan_err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("orph_sticky", orphan_err, 1'b1);
    rst_dut();
    #1;
    chk("orph_clear", orphan_err, 1'b0);

    // Reset on beat 2 of a 4-beat packet.
    s_tvalid = 4'b0100;
    s_tlast  = 4'b0100;
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (outstanding == 2'd1) break;
    end
    chk("mid_pre_outst", outstanding, 2'd1);
    s_tvalid = 4'b1000;
    s_tlast  = 4'b0000;
    @(negedge clk);
    #1;
    chk("mid_beat1_busy", busy, 1'b1);
    chk("mid_beat1_grant", grant_id, 2'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    s_tvalid = '0;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_outst", outstanding, 2'd0);
    chk("mid_s_tready", s_tready, 4'b0000);
    chk("mid_m_tvalid", m_tvalid, 1'b0);
    chk("mid_grant", grant_id, 2'd0);
    s_tvalid = 4'b1001;
    s_tlast  = 4'b1001;
    @(negedge clk);
    #1;
    chk("mid_new_busy", busy, 1'b1);
    chk("mid_new_grant", grant_id, 2'd0);
    s_tvalid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
